pc_unit: RTL
============

// Module: pc_unit
// PURPOSE
//   Parametrised program-counter unit for the fetch stage. Holds the PC and advances it by INC each
//   cycle. Supports stall, flush/redirect, taken branch, call/return through an internal
//   return-address stack (RAS), and a terminal halt state. Drives the fetch address and a valid
//   flag into instruction memory. Replaces the fixed 16-bit PC register.
// PARAMETERS
//   WIDTH      16  PC / address width in bits
//   RESET_VEC  0   PC value after reset (WIDTH bits)
//   INC        2   sequential increment (bytes per instruction)
//   RAS_DEPTH  4   return-address stack entries; power of 2, >=2
// PORTS
//   clk            in   1      clock, rising edge
//   rst_n          in   1      async active-low reset
//   stall          in   1      hold PC and RAS this cycle
//   flush_en       in   1      redirect to flush_target (mispredict/exception)
//   flush_target   in   WIDTH  flush destination
//   branch_en      in   1      taken branch/jump to branch_target
//   branch_target  in   WIDTH  branch destination
//   call_en        in   1      qualifies branch_en as a call: push pc+INC
//   ret_en         in   1      return: pop RAS into PC
//   halt           in   1      enter HALTED after this cycle
//   pc             out  WIDTH  current fetch address (registered)
//   pc_plus        out  WIDTH  pc+INC, combinational, modulo 2^WIDTH
//   pc_valid       out  1      fetch address valid
//   halted         out  1      unit is in HALTED
//   ras_empty      out  1      RAS holds 0 entries
//   ras_full       out  1      RAS holds RAS_DEPTH entries
//   ras_ovf        out  1      sticky: a push overwrote an entry
//   ras_unf        out  1      sticky: a pop found the RAS empty
// BEHAVIOUR
//   Reset (rst_n low, async): pc=RESET_VEC, state=BOOT, pc_valid=0, halted=0, RAS count=0,
//     ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0. All inputs are ignored while rst_n is low.
//   FSM: BOOT -> RUN unconditionally on the first edge after reset release (pc stays RESET_VEC).
//     RUN -> HALTED when halt=1 and no flush/stall. HALTED is terminal until reset.
//   pc_valid=1 only in RUN; halted=1 only in HALTED.
//   In HALTED, pc holds its value and all control inputs are ignored.
//   RUN next-pc priority, evaluated per rising edge (highest first):
//     1 flush_en : pc<=flush_target. RAS unchanged. halt/stall/branch/call/ret ignored.
//     2 stall    : pc, RAS and FSM hold.
//     3 halt     : pc holds, go HALTED. Branch/call/ret ignored.
//     4 branch_en: pc<=branch_target; if call_en also=1, push pc_plus.
//         ret_en with branch_en: ret is ignored, no pop.
//     5 ret_en   : if RAS non-empty, pc<=top and pop. If empty, pc<=pc_plus and ras_unf<=1.
//     6 else     : pc<=pc_plus.
//   call_en without branch_en: ignored, no push.
//   Latency: a redirect requested in cycle N is visible on pc in cycle N+1. No bubble is inserted.
//   RAS: circular buffer with a top pointer. Push when full overwrites the oldest entry, count stays
//     RAS_DEPTH, ras_ovf<=1. Sticky flags clear only on reset.
//   Arithmetic: pc_plus wraps modulo 2^WIDTH. For WIDTH=16, INC=2: 16'hFFFE -> 16'h0000, no flag.
//   Reset asserted mid-operation: immediate return to reset values. Any in-flight push/pop is lost.
// TESTING
//   T1 reset/boot: rst_n 0->1 -> pc=0, pc_valid=0 for 1 cycle, then pc=0,2,4,6 with pc_valid=1.
//   T2 call/ret: at pc=0x0010 branch_en+call_en, target 0x0100 -> pc=0x0100, RAS top=0x0012;
//      ret_en -> pc=0x0012, ras_empty=1.
//   T3 RAS overflow: 5 calls with RAS_DEPTH=4 -> ras_full=1, ras_ovf=1; 4 rets return the newest 4
//      addresses in LIFO order; 5th ret -> pc=pc+2, ras_unf=1.
//   T4 priority: flush_en+stall+branch_en same cycle, flush_target=0x0200 -> pc=0x0200, RAS unchanged;
//      stall alone 3 cycles -> pc constant.
//   T5 halt/wrap: pc=0xFFFE, no control -> pc=0x0000; halt=1 -> halted=1, pc_valid=0, pc frozen;
//      branch_en ignored; rst_n pulse -> pc=0, halted=0.
//   T6 async reset mid-call: assert rst_n low between edges during a call -> outputs reset at once,
//      without waiting for clk; RAS empty, ras_ovf/ras_unf=0.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter unit for the fetch stage.
// Holds the fetch PC, advances it by INC every cycle and applies flush,
// stall, halt, branch, call and return requests in fixed priority order.
// Call/return targets live in a small circular return-address stack; a push
// into a full stack overwrites the oldest entry.
module pc_unit #(
    parameter int unsigned WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned INC       = 2,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush_en,
    input  logic [WIDTH-1:0] flush_target,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             call_en,
    input  logic             ret_en,
    input  logic             halt,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             pc_valid,
    output logic             halted,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_ovf,
    output logic             ras_unf
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(RAS_DEPTH);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_pc_plus;

    // Stack storage: r_top indexes the newest entry, r_count how many are live.
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]    r_top;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_unf;

    logic             w_push;
    logic             w_pop;
    logic             w_unf_set;
    logic             w_empty;
    logic             w_full;
    logic [PW-1:0]    w_push_ptr;

    assign w_pc_plus  = r_pc + WIDTH'(INC);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_COUNT);
    // Power-of-two depth makes the pointer wrap naturally.
    assign w_push_ptr = r_top + PW'(1);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: BOOT always moves to RUN; a halt only takes effect when
    // neither a flush nor a stall outranks it; HALTED is terminal.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_BOOT:   w_state_next = ST_RUN;
            ST_RUN:    if (halt && !flush_en && !stall) w_state_next = ST_HALTED;
            ST_HALTED: w_state_next = ST_HALTED;
            default:   w_state_next = ST_BOOT;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        pc_valid = 1'b0;
        halted   = 1'b0;
        case (r_state)
            ST_RUN:    pc_valid = 1'b1;
            ST_HALTED: halted   = 1'b1;
            default: ;
        endcase
    end

    // Next-PC selection and stack requests, highest priority first.
    always_comb begin
        w_pc_next = r_pc;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_unf_set = 1'b0;
        if (r_state == ST_RUN) begin
            if (flush_en) begin
                w_pc_next = flush_target;
            end else if (stall || halt) begin
                w_pc_next = r_pc;
            end else if (branch_en) begin
                // A return paired with a branch is dropped; call needs branch.
                w_pc_next = branch_target;
                w_push    = call_en;
            end else if (ret_en) begin
                if (!w_empty) begin
                    w_pc_next = r_ras[r_top];
                    w_pop     = 1'b1;
                end else begin
                    w_pc_next = w_pc_plus;
                    w_unf_set = 1'b1;
                end
            end else begin
                w_pc_next = w_pc_plus;
            end
        end
    end

    // PC register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_VEC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // Stack pointer, occupancy and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_top   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_top <= w_push_ptr;
                if (w_full) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_count <= r_count + CW'(1);
                end
            end else if (w_pop) begin
                r_top   <= r_top - PW'(1);
                r_count <= r_count - CW'(1);
            end
            if (w_unf_set) begin
                r_unf <= 1'b1;
            end
        end
    end

    // Stack contents need no reset: occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[w_push_ptr] <= w_pc_plus;
        end
    end

    assign pc        = r_pc;
    assign pc_plus   = w_pc_plus;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;
    assign ras_ovf   = r_ovf;
    assign ras_unf   = r_unf;

endmodule
